// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared constants and helpers for the button event arbiter:
//               event-type encoding, default debounce length and a
//               width helper for counters.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

  // Event-type encoding carried in the FIFO and on evt_press.
  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  // Debounce length used when the integrator does not override it.
  localparam int DB_CYCLES_DEFAULT = 10000000;

  // Width of a counter that must hold values 0..value-1, never below 1 bit.
  function automatic int cnt_width(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer followed by a stable-count debouncer
//               for one button. Also reports whether the button has been
//               seen released since reset, so a button held through reset
//               does not generate a spurious press.
// Revision    : 1.0 - initial release
//
// Ports
//   clk       in   clock
//   rstn      in   asynchronous active-low reset
//   btn_raw   in   raw asynchronous button level (1 = pressed)
//   btn_level out  debounced level
//   btn_armed out  button observed released after reset
// ============================================================================
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_armed
);

  localparam int              c_cnt_w    = cnt_width(DB_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic               r_sync1;
  logic               r_sync2;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_level;
  logic [1:0]         r_prime;
  logic               r_armed;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_prime <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      // r_prime[1] marks that r_sync2 now reflects the real input rather
      // than the reset value of the synchronizer.
      r_prime <= {r_prime[0], 1'b1};

      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_one;
      end

      // Arm only once the button is genuinely seen released and settled.
      if (r_prime[1] && !r_sync2 && !r_level) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign btn_level = r_level;
  assign btn_armed = r_armed;

endmodule
`default_nettype wire

// File: rtl/btn_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : btn_event_arbiter
// Description : Debounces N_BTN buttons, turns level changes into per-button
//               pending events, arbitrates them round-robin into a
//               first-word-fall-through event FIFO.
// Revision    : 1.0 - initial release
//
// Build option
//   BTN_RELEASE_EVT_EN  defined: 1->0 level changes also emit release events.
//                       undefined: press events only, evt_press tied to 1.
//
// Ports
//   clk        in   clock
//   rstn       in   asynchronous active-low reset
//   btn_raw    in   [N_BTN] raw button levels (1 = pressed)
//   btn_level  out  [N_BTN] debounced levels
//   evt_valid  out  FIFO head holds an event
//   evt_ready  in   consumer accepts head event
//   evt_id     out  [$clog2(N_BTN)] button index of head event
//   evt_press  out  head event type, 1 = press, 0 = release
//   evt_ovf    out  sticky: an event was dropped
// ============================================================================
module btn_event_arbiter
  import btn_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int DB_CYCLES  = DB_CYCLES_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_BTN-1:0]         btn_raw,
  output logic [N_BTN-1:0]         btn_level,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic                     evt_press,
  output logic                     evt_ovf
);

  localparam int                 c_id_w    = $clog2(N_BTN);
  localparam int                 c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam logic [c_id_w-1:0]  c_id_one  = c_id_w'(1);
  localparam logic [c_id_w-1:0]  c_id_last = c_id_w'(N_BTN - 1);
  localparam logic [c_ptr_w:0]   c_ptr_one = (c_ptr_w + 1)'(1);

  logic [N_BTN-1:0]  w_armed;
  logic [N_BTN-1:0]  r_level_d;
  logic [N_BTN-1:0]  w_rise;
  logic [N_BTN-1:0]  w_new;
  logic [N_BTN-1:0]  r_pend;
  logic [N_BTN-1:0]  w_clr;
  logic [N_BTN-1:0]  w_load;
  logic [N_BTN-1:0]  w_drop;
  logic [c_id_w-1:0] r_rr_ptr;
  logic [c_id_w-1:0] w_gnt_id;
  logic [c_id_w-1:0] w_rr_next;
  logic              w_any;
  logic              r_ovf;
  logic [c_ptr_w:0]  r_wr_ptr;
  logic [c_ptr_w:0]  r_rd_ptr;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [c_id_w-1:0] r_mem_id [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // Per-button synchronizer and debouncer
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .rstn      (rstn),
      .btn_raw   (btn_raw[gi]),
      .btn_level (btn_level[gi]),
      .btn_armed (w_armed[gi])
    );
  end

  // --------------------------------------------------------------------------
  // Level-change detection; unarmed buttons (held through reset) are ignored
  // --------------------------------------------------------------------------
  assign w_rise = btn_level & ~r_level_d & w_armed;
`ifdef BTN_RELEASE_EVT_EN
  logic [N_BTN-1:0] w_fall;
  assign w_fall = ~btn_level & r_level_d & w_armed;
  assign w_new  = w_rise | w_fall;
`else
  assign w_new  = w_rise;
`endif

  // --------------------------------------------------------------------------
  // Round-robin arbiter: first pending index at or after r_rr_ptr
  // --------------------------------------------------------------------------
  function automatic logic [c_id_w-1:0] rot_idx(input logic [c_id_w-1:0] base,
                                                input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_BTN) sum = sum - N_BTN;
    return c_id_w'(sum);
  endfunction

  always_comb begin
    w_any    = 1'b0;
    w_gnt_id = '0;
    for (int k = 0; k < N_BTN; k++) begin
      if (!w_any && r_pend[rot_idx(r_rr_ptr, k)]) begin
        w_any    = 1'b1;
        w_gnt_id = rot_idx(r_rr_ptr, k);
      end
    end
  end

  assign w_rr_next = (w_gnt_id == c_id_last) ? '0 : w_gnt_id + c_id_one;

  // --------------------------------------------------------------------------
  // FIFO status; a pop in the same cycle does not free a slot for a push
  // --------------------------------------------------------------------------
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                   (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
  assign w_push  = w_any && !w_full;
  assign w_pop   = !w_empty && evt_ready;

  always_comb begin
    w_clr = '0;
    if (w_push) w_clr[w_gnt_id] = 1'b1;
  end

  // A slot being granted this cycle is free for a newly arriving event.
  assign w_load = w_new & (~r_pend | w_clr);
  assign w_drop = w_new & r_pend & ~w_clr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_level_d <= '0;
      r_pend    <= '0;
      r_rr_ptr  <= '0;
      r_ovf     <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
    end else begin
      r_level_d <= btn_level;
      r_pend    <= (r_pend & ~w_clr) | w_load;
      r_ovf     <= r_ovf | (|w_drop);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
        r_rr_ptr <= w_rr_next;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
    end
  end

  // Storage is not reset: contents are only observable while non-empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem_id[r_wr_ptr[c_ptr_w-1:0]] <= w_gnt_id;
  end

`ifdef BTN_RELEASE_EVT_EN
  logic [N_BTN-1:0] r_ptype;
  logic             r_mem_type [FIFO_DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptype <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (w_load[i]) r_ptype[i] <= w_rise[i] ? EVT_PRESS : EVT_RELEASE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem_type[r_wr_ptr[c_ptr_w-1:0]] <= r_ptype[w_gnt_id];
  end

  assign evt_press = r_mem_type[r_rd_ptr[c_ptr_w-1:0]];
`else
  assign evt_press = EVT_PRESS;
`endif

  assign evt_valid = !w_empty;
  assign evt_id    = r_mem_id[r_rd_ptr[c_ptr_w-1:0]];
  assign evt_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_event_arbiter
// Description : Directed self-checking bench for btn_event_arbiter with
//               DB_CYCLES=4, N_BTN=4, FIFO_DEPTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_event_arbiter;

  logic       clk;
  logic       rstn;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic       evt_press;
  logic       evt_ovf;

  int errors = 0;
  int checks = 0;
  int q[$];          // popped events, encoded id*2 + press
  logic seen;
  int exp_ovf;

  btn_event_arbiter #(
    .N_BTN      (4),
    .DB_CYCLES  (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_press (evt_press),
    .evt_ovf   (evt_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted event just after the falling edge.
  always @(negedge clk) begin
    #1;
    if (rstn && evt_valid && evt_ready) q.push_back(int'(evt_id) * 2 + int'(evt_press));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_evt(input string tag, input int id, input int press);
    int got;
    got = -1;
    if (q.size() > 0) got = q.pop_front();
    chk(tag, got, id * 2 + press);
  endtask

  task automatic expect_none(input string tag);
    chk(tag, q.size(), 0);
    q.delete();
  endtask

  initial begin
    rstn      = 1'b0;
    btn_raw   = 4'h0;
    evt_ready = 1'b1;
    cyc(3);
    chk("rst_valid", evt_valid, 0);
    chk("rst_level", btn_level, 0);
    chk("rst_ovf",   evt_ovf,   0);
    rstn = 1'b1;
    cyc(6);

    // Clean press of button 2: level after 6 cycles, event 2 cycles later.
    btn_raw[2] = 1'b1;
    cyc(5);
    chk("t1_level_early", btn_level[2], 0);
    cyc(1);
    chk("t1_level_6", btn_level[2], 1);
    cyc(1);
    chk("t1_valid_lat1", evt_valid, 0);
    cyc(1);
    chk("t1_valid_lat2", evt_valid, 1);
    chk("t1_id",    evt_id,    2);
    chk("t1_press", evt_press, 1);
    cyc(1);
    chk("t1_valid_1cyc", evt_valid, 0);
    cyc(1);
    btn_raw[2] = 1'b0;
    cyc(12);
    chk("t1_level_rel", btn_level[2], 0);
    expect_evt("t1_evt", 2, 1);
`ifdef BTN_RELEASE_EVT_EN
    expect_evt("t1_evt_rel", 2, 0);
`endif
    expect_none("t1_none");

    // Button 1 bouncing with 3-cycle pulses never settles.
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      btn_raw[1] = ((k / 3) % 2 == 0);
      @(negedge clk);
      seen |= btn_level[1];
    end
    btn_raw[1] = 1'b0;
    cyc(10);
    seen |= btn_level[1];
    chk("t2_glitch_level", seen, 0);
    expect_none("t2_glitch_none");

    // Grant button 1 so the round-robin pointer lands on 2.
    btn_raw[1] = 1'b1;
    cyc(10);
    btn_raw[1] = 1'b0;
    cyc(12);
    expect_evt("t3_prep", 1, 1);
`ifdef BTN_RELEASE_EVT_EN
    expect_evt("t3_prep_rel", 1, 0);
`endif
    expect_none("t3_prep_none");

    // All four settle together: order 2,3,0,1.
    btn_raw = 4'hF;
    cyc(14);
    expect_evt("t3_rr_a", 2, 1);
    expect_evt("t3_rr_b", 3, 1);
    expect_evt("t3_rr_c", 0, 1);
    expect_evt("t3_rr_d", 1, 1);
    expect_none("t3_rr_none");
    btn_raw = 4'h0;
    cyc(12);
`ifdef BTN_RELEASE_EVT_EN
    expect_evt("t3_rel_a", 2, 0);
    expect_evt("t3_rel_b", 3, 0);
    expect_evt("t3_rel_c", 0, 0);
    expect_evt("t3_rel_d", 1, 0);
`endif
    expect_none("t3_rel_none");

    // Back-pressure: fill the FIFO, pend one more, then overflow button 0.
    evt_ready = 1'b0;
    btn_raw[0] = 1'b1; cyc(1);
    btn_raw[1] = 1'b1; cyc(1);
    btn_raw[2] = 1'b1; cyc(1);
    btn_raw[3] = 1'b1;
    cyc(14);
    chk("t4_full_valid", evt_valid, 1);
    chk("t4_head_id",    evt_id,    0);
    chk("t4_head_press", evt_press, 1);
    btn_raw[0] = 1'b0; cyc(10);
    btn_raw[0] = 1'b1; cyc(10);
`ifdef BTN_RELEASE_EVT_EN
    exp_ovf = 1;
`else
    exp_ovf = 0;
`endif
    chk("t4_ovf_pending", evt_ovf, exp_ovf);
    btn_raw[0] = 1'b0; cyc(10);
    btn_raw[0] = 1'b1; cyc(10);
    chk("t4_ovf_set",    evt_ovf, 1);
    chk("t4_head_stable", evt_id, 0);
    expect_none("t4_no_pop");
    evt_ready = 1'b1;
    cyc(10);
    expect_evt("t4_drain_a", 0, 1);
    expect_evt("t4_drain_b", 1, 1);
    expect_evt("t4_drain_c", 2, 1);
    expect_evt("t4_drain_d", 3, 1);
`ifdef BTN_RELEASE_EVT_EN
    expect_evt("t4_drain_e", 0, 0);
`else
    expect_evt("t4_drain_e", 0, 1);
`endif
    expect_none("t4_drain_none");
    chk("t4_ovf_sticky", evt_ovf, 1);
    btn_raw = 4'h0;
    cyc(12);
`ifdef BTN_RELEASE_EVT_EN
    expect_evt("t4_rel_a", 1, 0);
    expect_evt("t4_rel_b", 2, 0);
    expect_evt("t4_rel_c", 3, 0);
    expect_evt("t4_rel_d", 0, 0);
`endif
    expect_none("t4_rel_none");

    // Press then release of button 3.
    btn_raw[3] = 1'b1; cyc(10);
    btn_raw[3] = 1'b0; cyc(12);
    expect_evt("t5_press", 3, 1);
`ifdef BTN_RELEASE_EVT_EN
    expect_evt("t5_release", 3, 0);
`endif
    expect_none("t5_none");

    // Reset with queued events and button 0 mid-debounce.
    evt_ready = 1'b0;
    btn_raw = 4'b1110;
    cyc(14);
    chk("t6_queued", evt_valid, 1);
    btn_raw[0] = 1'b1;
    cyc(4);
    rstn = 1'b0;
    #1;
    chk("t6_rst_valid", evt_valid, 0);
    chk("t6_rst_level", btn_level, 0);
    chk("t6_rst_ovf",   evt_ovf,   0);
    @(negedge clk);
    rstn = 1'b1;
    evt_ready = 1'b1;
    cyc(20);
    chk("t6_held_level", btn_level, 4'hF);
    chk("t6_held_valid", evt_valid, 0);
    expect_none("t6_held_none");
    btn_raw[0] = 1'b0; cyc(10);
    btn_raw[0] = 1'b1; cyc(12);
    expect_evt("t6_repress", 0, 1);
    expect_none("t6_end_none");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btn_event_arbiter.md
BTN_EVENT_ARBITER -- requirements
Module: btn_event_arbiter

Interface
REQ-001 Parameter N_BTN, default 4, SHALL set the number of raw button inputs (range 2..16).
REQ-002 Parameter DB_CYCLES, default 10000000, SHALL set the number of consecutive stable cycles needed to accept a level change.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL set the event FIFO depth (power of two, 2..16).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rstn  in  1  asynchronous, active-low reset.
REQ-006 btn_raw  in  N_BTN  asynchronous, bouncing button levels, 1 = pressed.
REQ-007 btn_level  out  N_BTN  debounced stable level per button.
REQ-008 evt_valid  out  1  FIFO head holds an event.
REQ-009 evt_ready  in  1  consumer accepts the head event when high with evt_valid.
REQ-010 evt_id  out  $clog2(N_BTN)  button index of the head event.
REQ-011 evt_press  out  1  head event type, 1 = press, 0 = release.
REQ-012 evt_ovf  out  1  sticky flag: an event was dropped.

Function
REQ-013 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Debounce: per-button counter SHALL clear whenever the synchronized level equals btn_level; otherwise it SHALL increment, and on the cycle it reaches DB_CYCLES-1 btn_level SHALL take the synchronized value and the counter SHALL clear.
REQ-015 Raw-to-btn_level latency for a clean edge SHALL be exactly 2 + DB_CYCLES cycles; a glitch shorter than DB_CYCLES cycles SHALL never change btn_level.
REQ-016 A 0->1 btn_level change SHALL set that button's pending bit with type press one cycle later.
REQ-017 If the button's pending bit is already set when a new event arrives, the new event SHALL be dropped, the pending event kept, and evt_ovf set.
REQ-018 Arbiter: each cycle with the FIFO not full and any pending bit set, it SHALL grant the first pending index at or after rr_ptr (wrapping), push {id,type}, clear that pending bit, and set rr_ptr to grant+1 mod N_BTN.
REQ-019 At most one push per cycle; no push SHALL occur on a cycle the FIFO is full, even if a pop occurs that cycle.
REQ-020 FIFO SHALL be first-word-fall-through: evt_valid = not empty; evt_id/evt_press SHALL be valid and stable while evt_valid is high and evt_ready is low.
REQ-021 A pop SHALL occur when evt_valid and evt_ready are both high; a pop on an empty FIFO SHALL have no effect.
REQ-022 Minimum latency from btn_level change to evt_valid on an idle, empty block SHALL be 2 cycles.
REQ-023 Pending events SHALL never be lost while the FIFO is full; they wait for a free slot.

Reset
REQ-024 rstn low SHALL immediately clear synchronizers, counters, btn_level, pending bits, FIFO pointers, rr_ptr, and evt_ovf; evt_valid SHALL read 0.
REQ-025 Reset asserted mid-debounce or with FIFO content SHALL discard all in-flight state; no event SHALL be emitted for a button already held at reset release until it is released and pressed again.
REQ-026 evt_ovf SHALL clear only on reset.

Configuration
REQ-027 Macro BTN_RELEASE_EVT_EN defined: a 1->0 btn_level change SHALL also set the pending bit with type release, under REQ-016 to REQ-023.
REQ-028 Macro undefined: release changes SHALL produce no event, and evt_press SHALL be constant 1.

Structure
REQ-029 Shared package btn_pkg SHALL hold the event-type constants (EVT_PRESS=1, EVT_RELEASE=0) and the default DB_CYCLES value.
REQ-030 Synchronizer plus debounce SHALL be the sub-module btn_debounce, instantiated N_BTN times; arbiter and FIFO SHALL remain in the top module.

Verification (DB_CYCLES=4, N_BTN=4, FIFO_DEPTH=4, evt_ready=1 unless stated)
REQ-031 btn_raw[2] rises, holds 10 cycles -> btn_level[2] rises 6 cycles after the edge, one event id=2 press, evt_valid high for exactly 1 cycle.
REQ-032 btn_raw[1] toggles with pulses of 3 cycles for 40 cycles -> btn_level[1] stays 0, no event.
REQ-033 Buttons 0,1,2,3 debounce on the same cycle, rr_ptr=2 -> events pop in order 2,3,0,1.
REQ-034 evt_ready=0, 6 press events on distinct cycles over 4 buttons -> 4 events queued, extra ones pending, no loss until a same-button repeat, then evt_ovf=1; raising evt_ready drains all non-dropped events in order.
REQ-035 Release-enabled build: press then release of button 3 -> events (3,press) then (3,release); disabled build -> only (3,press).
REQ-036 rstn pulsed low with 3 events queued and button 0 mid-debounce -> evt_valid=0, btn_level=0, evt_ovf=0 immediately; no event after release of reset while button 0 stays held.
